// File: rtl/sched_pkg.sv
// Shared scheduler definitions: FSM state encoding and the selector-width helper.
// Latency: none, types and constants only.
// Backpressure: none.
package sched_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  // Plain-vector aliases so state registers stay ordinary logic.
  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_XFER = XFER;

  // Selector width for n FIFOs. It never returns 0, so a single FIFO still gets a 1-bit index.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sched_axis_out_mux_if.sv
// Bundle between the scheduler/FIFO side, the output mux and the egress port.
// Latency: none, wires only.
// Backpressure: carries per-FIFO tready and egress tready; the slave is the mux.
interface sched_axis_out_mux_if
  import sched_pkg::*;
#(
  parameter int NUM_FIFO   = 9,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int SEL_WIDTH  = sel_w(NUM_FIFO)
);
  logic [SEL_WIDTH-1:0]             sel_in;
  logic                             en_in;
  logic [NUM_FIFO*DATA_WIDTH-1:0]   s_axis_tdata;
  logic [NUM_FIFO*KEEP_WIDTH-1:0]   s_axis_tkeep;
  logic [NUM_FIFO-1:0]              s_axis_tvalid;
  logic [NUM_FIFO-1:0]              s_axis_tlast;
  logic [NUM_FIFO-1:0]              s_axis_tready;
  logic [DATA_WIDTH-1:0]            m_axis_tdata;
  logic [KEEP_WIDTH-1:0]            m_axis_tkeep;
  logic                             m_axis_tvalid;
  logic                             m_axis_tlast;
  logic                             m_axis_tready;
  logic [NUM_FIFO-1:0]              pe_tlast;
  logic                             busy;

  modport slave (
    input  sel_in, en_in, s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, pe_tlast, busy
  );

  modport master (
    output sel_in, en_in, s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, pe_tlast, busy
  );
endinterface

// File: rtl/sched_axis_skid.sv
// Two-entry registered AXIS skid buffer (main output register plus one skid entry).
// Latency: 1 cycle from input handshake to output valid.
// Backpressure: in_rdy is a flop (skid entry empty), so out_rdy has no combinational path to in_rdy.
module sched_axis_skid #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_dat,
  input  logic [KEEP_WIDTH-1:0] in_keep,
  input  logic                  in_last,
  input  logic                  in_vld,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_dat,
  output logic [KEEP_WIDTH-1:0] out_keep,
  output logic                  out_last,
  output logic                  out_vld,
  input  logic                  out_rdy
);
  localparam int W = DATA_WIDTH + KEEP_WIDTH + 1;

  logic [W-1:0] main_q, main_d, skid_q, skid_d, in_pay;
  logic         main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic         in_fire, main_free;

  assign in_pay    = {in_last, in_keep, in_dat};
  assign in_rdy    = ~skid_vld_q;
  assign in_fire   = in_vld & ~skid_vld_q;
  assign main_free = ~main_vld_q | out_rdy;

  // The skid entry fills only while main is held. It drains into main before new input is taken, which preserves order.
  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (main_free) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = in_fire;
        if (in_fire) main_d = in_pay;
      end
    end else if (in_fire) begin
      skid_d     = in_pay;
      skid_vld_d = 1'b1;
    end
  end

  // Both entries clear on reset, so any buffered beats are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign out_dat  = main_q[DATA_WIDTH-1:0];
  assign out_keep = main_q[DATA_WIDTH +: KEEP_WIDTH];
  assign out_last = main_q[W-1];
  assign out_vld  = main_vld_q;
endmodule

// File: rtl/sched_axis_out_mux.sv
// Packet-granular output mux: locks onto the scheduler-selected FIFO for one packet and pulses pe_tlast at the end.
// Latency: selection in cycle N gives ready in N+1 and egress valid in N+2; one forced IDLE cycle after each packet.
// Backpressure: egress stalls fill the 2-entry skid, then the locked s_axis_tready drops (registered, no comb path).
module sched_axis_out_mux
  import sched_pkg::*;
#(
  parameter int NUM_FIFO   = 9,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int SEL_WIDTH  = sel_w(NUM_FIFO)
) (
  input logic                 clk,
  input logic                 rst_n,
  sched_axis_out_mux_if.slave bus
);
  logic [0:0]            state_q, state_d;
  logic [SEL_WIDTH-1:0]  lock_sel_q, lock_sel_d;
  logic [NUM_FIFO-1:0]   pe_tlast_q, pe_tlast_d;
  logic [NUM_FIFO-1:0]   s_rdy;
  logic                  sel_hit, lk_vld, lk_last, xfer, skid_in_rdy, in_fire;
  logic [DATA_WIDTH-1:0] lk_dat;
  logic [KEEP_WIDTH-1:0] lk_keep;

  assign xfer    = (state_q == ST_XFER);
  assign in_fire = xfer & lk_vld & skid_in_rdy;

  // Route the locked FIFO to the skid input and test the selection. An out-of-range index matches no FIFO.
  always_comb begin
    sel_hit = 1'b0;
    lk_vld  = 1'b0;
    lk_last = 1'b0;
    lk_dat  = '0;
    lk_keep = '0;
    s_rdy   = '0;
    for (int i = 0; i < NUM_FIFO; i++) begin
      if (bus.sel_in == SEL_WIDTH'(i)) sel_hit = bus.s_axis_tvalid[i];
      if (lock_sel_q == SEL_WIDTH'(i)) begin
        lk_vld  = bus.s_axis_tvalid[i];
        lk_last = bus.s_axis_tlast[i];
        lk_dat  = bus.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        lk_keep = bus.s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        s_rdy[i] = xfer & skid_in_rdy;
      end
    end
    sel_hit = sel_hit & bus.en_in;
  end

  // The last beat always returns to IDLE, so the scheduler sees pe_tlast before any new lock.
  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    pe_tlast_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (sel_hit) begin
          state_d    = ST_XFER;
          lock_sel_d = bus.sel_in;
        end
      end
      default: begin
        if (in_fire && lk_last) begin
          state_d = ST_IDLE;
          for (int i = 0; i < NUM_FIFO; i++) pe_tlast_d[i] = (lock_sel_q == SEL_WIDTH'(i));
        end
      end
    endcase
  end

  // Reset abandons any partial packet; no pe_tlast is generated for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      lock_sel_q <= '0;
      pe_tlast_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
      pe_tlast_q <= pe_tlast_d;
    end
  end

  sched_axis_skid #(
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP_WIDTH (KEEP_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_dat   (lk_dat),
    .in_keep  (lk_keep),
    .in_last  (lk_last),
    .in_vld   (xfer & lk_vld),
    .in_rdy   (skid_in_rdy),
    .out_dat  (bus.m_axis_tdata),
    .out_keep (bus.m_axis_tkeep),
    .out_last (bus.m_axis_tlast),
    .out_vld  (bus.m_axis_tvalid),
    .out_rdy  (bus.m_axis_tready)
  );

  assign bus.s_axis_tready = s_rdy;
  assign bus.pe_tlast      = pe_tlast_q;
  assign bus.busy          = xfer;
endmodule

// File: tb/tb_sched_axis_out_mux.sv
// Directed bench for sched_axis_out_mux: cycle table plus lock, backpressure and reset sequences.
// Latency: n/a.
// Backpressure: egress ready is driven from the table or from a fixed toggle pattern.
module tb_sched_axis_out_mux;
  localparam int NF = 9;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int SW = 4;
  localparam int NV = 17;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sched_axis_out_mux_if #(.NUM_FIFO(NF), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .SEL_WIDTH(SW)) bus ();

  sched_axis_out_mux #(.NUM_FIFO(NF), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .SEL_WIDTH(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [63:0] dat;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic        en;
    logic [3:0]  sel;
    logic        mrdy;
    logic        busy;
    logic [8:0]  srdy;
    logic        mvld;
    beat_t       b;
    logic [8:0]  pe;
  } vec_t;

  beat_t mem [NF][16];
  int    head [NF];
  int    tail [NF];
  int    pe_cnt [NF];
  beat_t eg [32];
  int    eg_n;
  int    in_cnt, out_cnt;
  int    n_checks = 0;
  int    n_errors = 0;
  vec_t  tv [NV];

  function automatic beat_t mk(input int f, input int k, input logic last);
    beat_t b;
    b.dat  = {32'(f), 32'(k)};
    b.keep = {4'(f), 4'(k)};
    b.last = last;
    return b;
  endfunction

  function automatic vec_t mv(input logic en, input logic [3:0] sel, input logic mrdy, input logic busy,
                              input logic [8:0] srdy, input logic mvld, input beat_t b, input logic [8:0] pe);
    vec_t v;
    v.en = en; v.sel = sel; v.mrdy = mrdy; v.busy = busy;
    v.srdy = srdy; v.mvld = mvld; v.b = b; v.pe = pe;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int f, input int k, input logic last);
    mem[f][tail[f]] = mk(f, k, last);
    tail[f]++;
  endtask

  task automatic drive_src();
    for (int i = 0; i < NF; i++) begin
      if (head[i] < tail[i]) begin
        bus.s_axis_tvalid[i]           = 1'b1;
        bus.s_axis_tdata[i*DW +: DW]   = mem[i][head[i]].dat;
        bus.s_axis_tkeep[i*KW +: KW]   = mem[i][head[i]].keep;
        bus.s_axis_tlast[i]            = mem[i][head[i]].last;
      end else begin
        bus.s_axis_tvalid[i]           = 1'b0;
        bus.s_axis_tdata[i*DW +: DW]   = '0;
        bus.s_axis_tkeep[i*KW +: KW]   = '0;
        bus.s_axis_tlast[i]            = 1'b0;
      end
    end
  endtask

  // One clock: record the handshakes that will happen at the coming edge, then advance the sources.
  task automatic tick();
    logic [NF-1:0] fire;
    logic          mfire;
    fire  = bus.s_axis_tvalid & bus.s_axis_tready;
    mfire = bus.m_axis_tvalid & bus.m_axis_tready;
    chk("tready_onehot", 64'($countones(bus.s_axis_tready) <= 1), 64'd1);
    if (mfire && eg_n < 32) begin
      eg[eg_n].dat  = bus.m_axis_tdata;
      eg[eg_n].keep = bus.m_axis_tkeep;
      eg[eg_n].last = bus.m_axis_tlast;
      eg_n++;
    end
    @(posedge clk);
    #1;
    if (rst_n) begin
      for (int i = 0; i < NF; i++) if (fire[i] && head[i] < tail[i]) head[i]++;
      in_cnt  += $countones(fire);
      out_cnt += int'(mfire);
    end
    for (int i = 0; i < NF; i++) if (bus.pe_tlast[i]) pe_cnt[i]++;
    drive_src();
  endtask

  task automatic chk_eg(input string name, input int idx, input int f, input int k, input logic last);
    beat_t e;
    e = mk(f, k, last);
    chk({name, "_dat"}, eg[idx].dat, e.dat);
    chk({name, "_keep_last"}, {eg[idx].keep, eg[idx].last}, {e.keep, e.last});
  endtask

  initial begin
    int   occ;
    logic saw_full;

    bus.sel_in = '0; bus.en_in = 1'b0; bus.m_axis_tready = 1'b0;
    bus.s_axis_tdata = '0; bus.s_axis_tkeep = '0; bus.s_axis_tvalid = '0; bus.s_axis_tlast = '0;
    for (int i = 0; i < NF; i++) begin head[i] = 0; tail[i] = 0; pe_cnt[i] = 0; end
    eg_n = 0; in_cnt = 0; out_cnt = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_tvalid", bus.m_axis_tvalid, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_tready", bus.s_axis_tready, 0);
    chk("rst_tdata", bus.m_axis_tdata, 0);
    chk("rst_tkeep", bus.m_axis_tkeep, 0);
    chk("rst_tlast", bus.m_axis_tlast, 0);
    chk("rst_pe", bus.pe_tlast, 0);

    // Cycle table: basic 3-beat packet on FIFO 4, ignored selects, FIFO 4 single beat, back-to-back singles on 0 and 1.
    push(4, 0, 1'b0); push(4, 1, 1'b0); push(4, 2, 1'b1); push(4, 3, 1'b1);
    push(0, 0, 1'b1); push(1, 0, 1'b1);
    tv[0]  = mv(1, 4'd4,  1, 0, 9'h000, 0, '0,            9'h000);
    tv[1]  = mv(0, 4'd0,  1, 1, 9'h010, 0, '0,            9'h000);
    tv[2]  = mv(0, 4'd0,  1, 1, 9'h010, 1, mk(4, 0, 0),   9'h000);
    tv[3]  = mv(0, 4'd0,  1, 1, 9'h010, 1, mk(4, 1, 0),   9'h000);
    tv[4]  = mv(0, 4'd0,  1, 0, 9'h000, 1, mk(4, 2, 1),   9'h010);
    tv[5]  = mv(1, 4'd5,  1, 0, 9'h000, 0, '0,            9'h000);
    tv[6]  = mv(1, 4'd12, 1, 0, 9'h000, 0, '0,            9'h000);
    tv[7]  = mv(0, 4'd4,  1, 0, 9'h000, 0, '0,            9'h000);
    tv[8]  = mv(1, 4'd4,  1, 0, 9'h000, 0, '0,            9'h000);
    tv[9]  = mv(0, 4'd0,  1, 1, 9'h010, 0, '0,            9'h000);
    tv[10] = mv(0, 4'd0,  1, 0, 9'h000, 1, mk(4, 3, 1),   9'h010);
    tv[11] = mv(1, 4'd0,  1, 0, 9'h000, 0, '0,            9'h000);
    tv[12] = mv(1, 4'd1,  1, 1, 9'h001, 0, '0,            9'h000);
    tv[13] = mv(1, 4'd1,  1, 0, 9'h000, 1, mk(0, 0, 1),   9'h001);
    tv[14] = mv(0, 4'd0,  1, 1, 9'h002, 0, '0,            9'h000);
    tv[15] = mv(0, 4'd0,  1, 0, 9'h000, 1, mk(1, 0, 1),   9'h002);
    tv[16] = mv(0, 4'd0,  1, 0, 9'h000, 0, '0,            9'h000);
    drive_src();
    for (int r = 0; r < NV; r++) begin
      bus.en_in = tv[r].en;
      bus.sel_in = tv[r].sel;
      bus.m_axis_tready = tv[r].mrdy;
      chk($sformatf("row%0d_busy", r), bus.busy, tv[r].busy);
      chk($sformatf("row%0d_tready", r), bus.s_axis_tready, tv[r].srdy);
      chk($sformatf("row%0d_mvalid", r), bus.m_axis_tvalid, tv[r].mvld);
      chk($sformatf("row%0d_pe", r), bus.pe_tlast, tv[r].pe);
      if (tv[r].mvld) begin
        chk($sformatf("row%0d_mdata", r), bus.m_axis_tdata, tv[r].b.dat);
        chk($sformatf("row%0d_mkeep", r), bus.m_axis_tkeep, tv[r].b.keep);
        chk($sformatf("row%0d_mlast", r), bus.m_axis_tlast, tv[r].b.last);
      end
      tick();
    end

    // Lock stability: FIFO 7 is requested throughout FIFO 2's packet.
    push(2, 0, 0); push(2, 1, 0); push(2, 2, 0); push(2, 3, 1);
    push(7, 0, 0); push(7, 1, 1);
    eg_n = 0;
    drive_src();
    bus.en_in = 1'b1; bus.sel_in = 4'd2; bus.m_axis_tready = 1'b1;
    tick();
    bus.sel_in = 4'd7;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("lock_tready_c%0d", c), bus.s_axis_tready, 9'h004);
      tick();
    end
    chk("lock_idle_busy", bus.busy, 0);
    chk("lock_idle_tready", bus.s_axis_tready, 0);
    chk("lock_idle_pe", bus.pe_tlast, 9'h004);
    tick();
    chk("lock_next_tready", bus.s_axis_tready, 9'h080);
    chk("lock_next_busy", bus.busy, 1);
    bus.en_in = 1'b0;
    for (int c = 0; c < 20 && eg_n < 6; c++) tick();
    chk("lock_egress_count", eg_n, 6);
    for (int k = 0; k < 4; k++) chk_eg($sformatf("lock_f2_b%0d", k), k, 2, k, k == 3);
    for (int k = 0; k < 2; k++) chk_eg($sformatf("lock_f7_b%0d", k), 4 + k, 7, k, k == 1);
    repeat (2) tick();

    // Egress backpressure: 8 beats on FIFO 6, ready pattern 1,0,0,1.
    for (int k = 0; k < 8; k++) push(6, k, k == 7);
    eg_n = 0; in_cnt = 0; out_cnt = 0; saw_full = 1'b0;
    for (int i = 0; i < NF; i++) pe_cnt[i] = 0;
    drive_src();
    bus.en_in = 1'b1; bus.sel_in = 4'd6; bus.m_axis_tready = 1'b1;
    tick();
    bus.en_in = 1'b0;
    for (int c = 0; c < 80 && eg_n < 8; c++) begin
      bus.m_axis_tready = (c % 4 == 0) || (c % 4 == 3);
      occ = in_cnt - out_cnt;
      chk("bp_occupancy", 64'(occ <= 2), 64'd1);
      if (occ == 2) begin
        saw_full = 1'b1;
        chk("bp_tready_full", bus.s_axis_tready[6], 0);
      end
      tick();
    end
    chk("bp_saw_full", saw_full, 1);
    chk("bp_egress_count", eg_n, 8);
    for (int k = 0; k < 8; k++) chk_eg($sformatf("bp_b%0d", k), k, 6, k, k == 7);
    chk("bp_pe_count", pe_cnt[6], 1);
    bus.m_axis_tready = 1'b1;
    repeat (2) tick();

    // Async reset after 2 of 5 beats on FIFO 3.
    for (int k = 0; k < 5; k++) push(3, k, k == 4);
    for (int i = 0; i < NF; i++) pe_cnt[i] = 0;
    eg_n = 0;
    drive_src();
    bus.en_in = 1'b1; bus.sel_in = 4'd3;
    tick();
    bus.en_in = 1'b0;
    tick();
    tick();
    chk("rstm_busy_before", bus.busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstm_tready", bus.s_axis_tready, 0);
    chk("rstm_mvalid", bus.m_axis_tvalid, 0);
    chk("rstm_mlast", bus.m_axis_tlast, 0);
    chk("rstm_mdata", bus.m_axis_tdata, 0);
    chk("rstm_mkeep", bus.m_axis_tkeep, 0);
    chk("rstm_pe", bus.pe_tlast, 0);
    chk("rstm_busy", bus.busy, 0);
    head[3] = tail[3];
    drive_src();
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("rstm_busy_after", bus.busy, 0);
    chk("rstm_pe_count", pe_cnt[3], 0);
    push(8, 0, 0); push(8, 1, 1);
    eg_n = 0;
    drive_src();
    bus.en_in = 1'b1; bus.sel_in = 4'd8;
    tick();
    bus.en_in = 1'b0;
    for (int c = 0; c < 10 && eg_n < 2; c++) tick();
    chk("rstm_new_count", eg_n, 2);
    chk_eg("rstm_new_b0", 0, 8, 0, 0);
    chk_eg("rstm_new_b1", 1, 8, 1, 1);
    chk("rstm_new_pe8", pe_cnt[8], 1);
    chk("rstm_new_pe3", pe_cnt[3], 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sched_axis_out_mux.md
# sched_axis_out_mux

Packet-granular AXI-Stream output multiplexer downstream of the PIEO scheduler. Consumes the scheduler's `sel_out`/`en_out` and locks onto the selected FIFO for one whole packet. It forwards the packet beats through a registered skid stage to the egress port and returns a per-FIFO end-of-packet pulse. That pulse drives the scheduler's `pe_tlast` input.

## Interface
Parameters:
- `NUM_FIFO`, 9: number of input FIFOs (`PORT_COUNT*N_FIFO_PER_PORT`)
- `DATA_WIDTH`, 64: AXIS data width
- `KEEP_WIDTH`, `DATA_WIDTH/8`: tkeep width
- `SEL_WIDTH`, `$clog2(NUM_FIFO)`: selector width

Ports:
- `clk` in 1: single clock; all logic on rising edge
- `rst_n` in 1: reset, asynchronous assert, active-low
- `sel_in` in SEL_WIDTH: FIFO index from scheduler `sel_out`
- `en_in` in 1: selection valid, from scheduler `en_out`
- `s_axis_tdata` in NUM_FIFO*DATA_WIDTH: packed FIFO data, FIFO i at slice i
- `s_axis_tkeep` in NUM_FIFO*KEEP_WIDTH: packed keep
- `s_axis_tvalid` in NUM_FIFO: per-FIFO valid
- `s_axis_tlast` in NUM_FIFO: per-FIFO last
- `s_axis_tready` out NUM_FIFO: per-FIFO ready, at most one bit high
- `m_axis_tdata` out DATA_WIDTH: egress data
- `m_axis_tkeep` out KEEP_WIDTH: egress keep
- `m_axis_tvalid` out 1: egress valid
- `m_axis_tlast` out 1: egress last
- `m_axis_tready` in 1: egress ready
- `pe_tlast` out NUM_FIFO: one-cycle pulse on bit i when the last beat of FIFO i is accepted
- `busy` out 1: high while a packet is locked

## Operation
- FSM states are IDLE and XFER. A register `lock_sel` holds the locked FIFO index.
- IDLE:
  - If `en_in`, `sel_in < NUM_FIFO` and `s_axis_tvalid[sel_in]`, capture `lock_sel <= sel_in` and go to XFER.
  - Otherwise stay in IDLE. A selection of an empty or out-of-range FIFO is ignored.
- XFER:
  - `s_axis_tready[lock_sel] = skid_in_ready`; all other ready bits are 0.
  - `sel_in`/`en_in` are ignored for the whole packet.
  - A beat is accepted when `s_axis_tvalid[lock_sel] && s_axis_tready[lock_sel]`.
  - When the accepted beat has tlast: go to IDLE and register `pe_tlast[lock_sel]` high for exactly one cycle.
- Mandatory IDLE cycle: the cycle after the last beat is always IDLE, so the scheduler observes `pe_tlast` before a new lock. There is never a direct XFER→XFER transition.
- Skid stage:
  - Two entries (main plus skid).
  - `skid_in_ready` is registered: it equals "skid entry empty", so `m_axis_tready` never reaches `s_axis_tready` combinationally.
  - Preserves order and never drops or duplicates a beat.
- Data, keep and last pass through unchanged.
- A single-beat packet (tlast on the first beat) is legal.
- Reset mid-packet clears the FSM and the skid stage. The partial packet is abandoned with no `pe_tlast`.

## Timing
Reset values:
- `s_axis_tready = 0`, `m_axis_tvalid = 0`, `m_axis_tlast = 0`, `pe_tlast = 0`, `busy = 0`
- `m_axis_tdata`, `m_axis_tkeep` = 0
- FSM = IDLE, `lock_sel = 0`

Latency:
- Selection seen in cycle N gives XFER and ready in N+1.
- First input handshake at the earliest in N+1.
- `m_axis_tvalid` at N+2.

Throughput:
- One beat per cycle while `m_axis_tready` stays high.
- Per-packet overhead is one IDLE cycle plus the selection cycle.

Other timing:
- `pe_tlast` is asserted in the cycle after the last input handshake, coincident with IDLE.
- `busy` is high exactly in XFER.
- Egress stall: `m_axis_tready` low for k cycles lets at most 2 beats be buffered, then `s_axis_tready` drops. Beats resume in order once ready returns.
- If `en_in` rises in the same cycle as the last handshake, it is ignored; it is re-evaluated in the IDLE cycle.

## Structure
- Shared package `sched_pkg`:
  - state enum `{IDLE, XFER}`
  - localparam helper for `SEL_WIDTH`, common with `pieo_sched`
- Sub-module `sched_axis_skid`: the two-entry registered AXIS skid buffer with DATA, KEEP and LAST, plus the same clk/rst_n.
- Top level: FSM, lock register, input mux, `pe_tlast` generation.

## Test plan
- **Basic packet:** reset, then `en_in=1`, `sel_in=4`, FIFO 4 presents 3 beats (D0..D2, tlast on D2), `m_axis_tready=1`.
  - Egress shows D0..D2 in cycles N+2..N+4 with tlast on D2.
  - `pe_tlast=9'b000010000` for one cycle.
  - `busy` is high 3 cycles.
- **Lock stability:** mid-packet on FIFO 2, `sel_in` changes to 7 with FIFO 7 valid.
  - `s_axis_tready[7]` stays 0 until FIFO 2's tlast plus one IDLE cycle.
  - The next packet comes from 7.
- **Egress backpressure:** 8-beat packet, `m_axis_tready` toggles 1,0,0,1 repeatedly.
  - All 8 beats arrive in order with none lost or duplicated.
  - `s_axis_tready` drops after 2 buffered beats.
- **Ignored selects:** `en_in=1`, `sel_in=5` with FIFO 5 not valid; also `sel_in=12` (out of range, with a 4-bit sel).
  - FSM stays IDLE and all `s_axis_tready` are 0.
- **Back-to-back single-beat packets:** from FIFOs 0 and 1.
  - Exactly one IDLE cycle between them.
  - `pe_tlast` bits 0 then 1, each pulsed once.
- **Async reset mid-packet:** assert `rst_n=0` after beat 2 of 5.
  - All outputs are 0 immediately, without waiting for a clock edge.
  - No `pe_tlast`.
  - After release, a new packet transfers normally.
